joybus_resp_decoder: RTL and testbench
======================================

JOYBUS_RESP_DECODER -- requirements
Module: joybus_resp_decoder

Interface
REQ-001 SHALL have parameter CYC_PER_US, default 50, meaning clk cycles per microsecond.
REQ-002 SHALL have parameter TIMEOUT_US, default 100, meaning the maximum wait in microseconds for any expected line edge.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port jb_in, input, 1 bit: the raw, asynchronous JOYBUS line level, idle high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that arms reception after the host finishes its poll command.
REQ-007 SHALL have port cntlr_data, output, 32 bits: the last successfully decoded controller response, MSB first on the wire.
REQ-008 SHALL have port cntlr_data_rdy, output, 1 bit: one-cycle pulse that marks a new value on cntlr_data.
REQ-009 SHALL have port rx_err, output, 1 bit: one-cycle pulse on timeout or malformed bit.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL pass jb_in through a 2-flop synchronizer (both flops reset to 1); all decoding uses the second flop (jb_s) and its previous value for edge detection.
REQ-012 SHALL implement the states IDLE, WAIT_FALL, LOW, HIGH, STOP_LOW.
REQ-013 IDLE: on start=1, SHALL go to WAIT_FALL with bit_cnt=0 and timer=0; start in any other state SHALL be ignored.
REQ-014 WAIT_FALL/HIGH: on a jb_s falling edge, SHALL go to LOW with low_cnt=0; otherwise SHALL increment timer.
REQ-015 LOW: SHALL increment low_cnt every cycle; on a jb_s rising edge, SHALL shift bit = (low_cnt < 2*CYC_PER_US) into shift[0] (left shift), increment bit_cnt, and clear timer.
REQ-016 After the 32nd data bit, SHALL go to HIGH and treat the next low pulse as the stop bit (state STOP_LOW); otherwise SHALL go to HIGH.
REQ-017 STOP_LOW: on a rising edge, SHALL load cntlr_data<=shift, pulse cntlr_data_rdy for exactly the next cycle, and return to IDLE; the stop-bit low duration SHALL NOT be checked against a threshold but is subject to REQ-019.
REQ-018 SHALL raise the timeout (rx_err pulse, go to IDLE, cntlr_data unchanged) when timer reaches TIMEOUT_US*CYC_PER_US in WAIT_FALL or HIGH.
REQ-019 SHALL treat low_cnt reaching 4*CYC_PER_US in LOW or STOP_LOW as malformed (rx_err pulse, go to IDLE, cntlr_data unchanged).
REQ-020 low_cnt SHALL be at least clog2(4*CYC_PER_US+1) bits wide and timer at least clog2(TIMEOUT_US*CYC_PER_US+1) bits wide; neither SHALL wrap before its check fires.
REQ-021 cntlr_data_rdy and rx_err SHALL never be high in the same cycle, and each SHALL be a single-cycle pulse.
REQ-022 Exactly at the threshold low_cnt == 2*CYC_PER_US, the decoded bit SHALL be 0.

Reset
REQ-023 While rst_n=0 at a clk edge: state SHALL be IDLE, cntlr_data SHALL be 32'h0, cntlr_data_rdy, rx_err and busy SHALL be 0, shift, bit_cnt, low_cnt and timer SHALL be 0, and both synchronizer flops SHALL be 1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame without producing any rdy or err pulse; the first start after reset SHALL begin a clean frame.

Verification
REQ-025 Drive start, then 32 bits encoding 32'h80000000 (1 = 1us low/3us high, 0 = 3us low/1us high), then a 2us stop -> one cntlr_data_rdy pulse, cntlr_data=32'h80000000, busy drops the same cycle.
REQ-026 Frame with pattern 32'hA5A5_0F7F -> cntlr_data=32'hA5A50F7F; then a second frame of 32'h00000000 -> cntlr_data updates to 0.
REQ-027 Start with the line held high -> rx_err pulse exactly 5000 cycles after entering WAIT_FALL; cntlr_data retains its prior value.
REQ-028 Hold the line low for 5us during bit 10 -> rx_err pulse when low_cnt reaches 200 cycles, no rdy pulse, return to IDLE.
REQ-029 Low pulse exactly 100 cycles (as seen after the synchronizer) -> bit decodes as 0; 99 cycles -> bit decodes as 1.
REQ-030 Assert rst_n=0 during bit 20, release, then run a start pulse and a valid 32'h12345678 frame -> only one rdy pulse, cntlr_data=32'h12345678; a start pulse while busy is ignored.

Source files
------------

// File: rtl/joybus_resp_decoder.sv
// -----------------------------------------------------------------------------
// joybus_resp_decoder
//
// Receives the 32-bit controller response that follows a host poll command on
// a JOYBUS line. Each bit is a low pulse followed by a high interval. A short
// low pulse is a 1 and a long low pulse is a 0. After 32 data bits, one more
// low pulse acts as the stop bit and completes the frame.
//
// Parameters
//   CYC_PER_US  clk cycles per microsecond
//   TIMEOUT_US  longest wait, in microseconds, for any expected line edge
//
// Ports
//   clk             single clock; all logic runs on its rising edge
//   rst_n           synchronous, active-low reset
//   jb_in           raw asynchronous JOYBUS level, idle high
//   start           one-cycle pulse that arms reception (ignored while busy)
//   cntlr_data      last successfully decoded response, MSB first on the wire
//   cntlr_data_rdy  one-cycle pulse when cntlr_data takes a new value
//   rx_err          one-cycle pulse on edge timeout or overlong low pulse
//   busy            high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module joybus_resp_decoder #(
  parameter int CYC_PER_US = 50,
  parameter int TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jb_in,
  input  logic        start,
  output logic [31:0] cntlr_data,
  output logic        cntlr_data_rdy,
  output logic        rx_err,
  output logic        busy
);

  localparam int BIT_THR = 2 * CYC_PER_US;          // low cycles that decode as 0
  localparam int LOW_MAX = 4 * CYC_PER_US;          // low cycles that mean malformed
  localparam int TMO     = TIMEOUT_US * CYC_PER_US; // cycles to wait for an edge
  localparam int LW      = $clog2(LOW_MAX + 1);
  localparam int TW      = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    LOW,
    HIGH,
    STOP_LOW
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_jb_s;
  logic            r_jb_s_d;
  logic [31:0]     r_shift;
  logic [5:0]      r_bit_cnt;
  logic [LW-1:0]   r_low_cnt;
  logic [TW-1:0]   r_timer;
  logic [31:0]     r_data;
  logic            r_rdy;
  logic            r_err;

  logic            w_fall;
  logic            w_rise;
  logic [LW-1:0]   w_low_nxt;
  logic            w_low_ovf;
  logic            w_bit;
  logic            w_tmo;

  assign w_fall    = r_jb_s_d & ~r_jb_s;
  assign w_rise    = ~r_jb_s_d & r_jb_s;

  // The bit decision uses the count including the current cycle, so a pulse
  // seen low for exactly BIT_THR cycles decodes as 0 and one cycle less as 1.
  assign w_low_nxt = r_low_cnt + LW'(1);
  assign w_low_ovf = (w_low_nxt == LW'(LOW_MAX));
  assign w_bit     = (w_low_nxt < LW'(BIT_THR));

  // Fires on the cycle in which the timer would reach TMO.
  assign w_tmo     = (r_timer == TW'(TMO - 1));

  assign cntlr_data     = r_data;
  assign cntlr_data_rdy = r_rdy;
  assign rx_err         = r_err;
  assign busy           = (r_state != IDLE);

  // Two-flop synchronizer plus one delayed copy for edge detection. All three
  // reset to the idle line level so that no edge is seen when reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_jb_s   <= 1'b1;
      r_jb_s_d <= 1'b1;
    end else begin
      r_sync1  <= jb_in;
      r_jb_s   <= r_sync1;
      r_jb_s_d <= r_jb_s;
    end
  end

  // Receive FSM with registered outputs. The rdy and err pulses default low
  // every cycle, so each can only be a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_low_cnt <= '0;
      r_timer   <= '0;
      r_data    <= '0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= WAIT_FALL;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_shift   <= '0;
          end
        end

        WAIT_FALL, HIGH: begin
          if (w_fall) begin
            r_low_cnt <= '0;
            // The low pulse after the 32nd data bit is the stop bit.
            r_state   <= (r_bit_cnt == 6'd32) ? STOP_LOW : LOW;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        LOW: begin
          r_low_cnt <= w_low_nxt;
          // An overlong pulse wins even if the line rises in the same cycle.
          if (w_low_ovf) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (w_rise) begin
            r_shift   <= {r_shift[30:0], w_bit};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_timer   <= '0;
            r_state   <= HIGH;
          end
        end

        STOP_LOW: begin
          r_low_cnt <= w_low_nxt;
          if (w_low_ovf) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (w_rise) begin
            r_data  <= r_shift;
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_resp_decoder.sv
// -----------------------------------------------------------------------------
// tb_joybus_resp_decoder
//
// Directed bench for joybus_resp_decoder at CYC_PER_US = 50, TIMEOUT_US = 100.
// A 1 bit is 50 low / 150 high cycles, a 0 bit is 150 low / 50 high cycles,
// and the stop bit is 100 low cycles followed by idle high.
// -----------------------------------------------------------------------------
module tb_joybus_resp_decoder;

  logic        clk;
  logic        rst_n;
  logic        jb_in;
  logic        start;
  logic [31:0] cntlr_data;
  logic        cntlr_data_rdy;
  logic        rx_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Pulse bookkeeping, written only by the monitor below.
  int rdy_cnt      = 0;
  int err_cnt      = 0;
  int rdy_busy_bad = 0;
  int both_bad     = 0;
  int long_bad     = 0;
  logic rdy_prev   = 1'b0;
  logic err_prev   = 1'b0;

  joybus_resp_decoder #(
    .CYC_PER_US (50),
    .TIMEOUT_US (100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jb_in          (jb_in),
    .start          (start),
    .cntlr_data     (cntlr_data),
    .cntlr_data_rdy (cntlr_data_rdy),
    .rx_err         (rx_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cntlr_data_rdy) rdy_cnt++;
    if (rx_err) err_cnt++;
    if (cntlr_data_rdy && busy) rdy_busy_bad++;
    if (cntlr_data_rdy && rx_err) both_bad++;
    if ((cntlr_data_rdy && rdy_prev) || (rx_err && err_prev)) long_bad++;
    rdy_prev = cntlr_data_rdy;
    err_prev = rx_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send_pulse(input int low_cyc, input int high_cyc);
    jb_in = 1'b0;
    step(low_cyc);
    jb_in = 1'b1;
    step(high_cyc);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(50, 150);
    else   send_pulse(150, 50);
  endtask

  // Sends bits [31:31-nbits+1] of v; optionally pulses start after bit index
  // inject_after (counted from 0 at the MSB) while the line is high.
  task automatic send_bits(input logic [31:0] v, input int nbits, input int inject_after);
    for (int i = 0; i < nbits; i++) begin
      send_bit(v[31-i]);
      if (i == inject_after) pulse_start();
    end
  endtask

  task automatic send_stop();
    send_pulse(100, 20);
  endtask

  task automatic send_frame(input logic [31:0] v, input int inject_after);
    pulse_start();
    send_bits(v, 32, inject_after);
    send_stop();
  endtask

  initial begin
    int n;
    int rdy0;
    int err0;

    rst_n = 1'b0;
    jb_in = 1'b1;
    start = 1'b0;
    step(5);
    chk("reset_data", cntlr_data, 32'h0);
    chk("reset_rdy", {31'h0, cntlr_data_rdy}, 32'h0);
    chk("reset_err", {31'h0, rx_err}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    step(3);

    // Single frame, MSB set only.
    pulse_start();
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    send_bits(32'h8000_0000, 32, -1);
    send_stop();
    chk("f1_rdy_count", rdy_cnt, 1);
    chk("f1_data", cntlr_data, 32'h8000_0000);
    chk("f1_busy", {31'h0, busy}, 32'h0);
    chk("f1_err_count", err_cnt, 0);
    chk("f1_busy_at_rdy", rdy_busy_bad, 0);

    // Line stays high after start: timeout after 5000 cycles.
    pulse_start();
    n = 0;
    while (!rx_err && n < 6000) begin
      step(1);
      n++;
    end
    chk("tmo_cycles", n, 5000);
    chk("tmo_busy", {31'h0, busy}, 32'h0);
    step(5);
    chk("tmo_err_count", err_cnt, 1);
    chk("tmo_data_kept", cntlr_data, 32'h8000_0000);
    chk("tmo_rdy_count", rdy_cnt, 1);

    // Mixed pattern, then all zeros.
    send_frame(32'hA5A5_0F7F, -1);
    chk("f2_data", cntlr_data, 32'hA5A5_0F7F);
    chk("f2_rdy_count", rdy_cnt, 2);
    send_frame(32'h0000_0000, -1);
    chk("f3_data", cntlr_data, 32'h0000_0000);
    chk("f3_rdy_count", rdy_cnt, 3);

    // Threshold: 100 low cycles decode as 0, 99 as 1.
    pulse_start();
    send_pulse(100, 100);
    send_pulse(99, 101);
    send_bits(32'h0000_0000, 30, -1);
    send_stop();
    chk("thr_data", cntlr_data, 32'h4000_0000);
    chk("thr_rdy_count", rdy_cnt, 4);

    // Line held low during bit 10: error when the low count reaches 200.
    // The drop is seen as a fall 3 edges later, then 200 more cycles low.
    rdy0 = rdy_cnt;
    err0 = err_cnt;
    pulse_start();
    send_bits(32'hFFFF_FFFF, 10, -1);
    jb_in = 1'b0;
    n = 0;
    while (!rx_err && n < 400) begin
      step(1);
      n++;
    end
    chk("long_low_cycles", n, 203);
    chk("long_low_busy", {31'h0, busy}, 32'h0);
    step(60);
    jb_in = 1'b1;
    step(20);
    chk("long_low_err_count", err_cnt, err0 + 1);
    chk("long_low_rdy_count", rdy_cnt, rdy0);
    chk("long_low_data_kept", cntlr_data, 32'h4000_0000);
    chk("long_low_idle", {31'h0, busy}, 32'h0);

    // Reset during bit 20 abandons the frame silently.
    rdy0 = rdy_cnt;
    err0 = err_cnt;
    pulse_start();
    send_bits(32'h1234_5678, 20, -1);
    jb_in = 1'b0;
    step(30);
    rst_n = 1'b0;
    step(3);
    chk("midrst_data", cntlr_data, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    jb_in = 1'b1;
    rst_n = 1'b1;
    step(20);
    chk("midrst_rdy_count", rdy_cnt, rdy0);
    chk("midrst_err_count", err_cnt, err0);

    // Clean frame after reset, with a stray start pulse mid-frame.
    send_frame(32'h1234_5678, 5);
    chk("post_rst_data", cntlr_data, 32'h1234_5678);
    chk("post_rst_rdy_count", rdy_cnt, rdy0 + 1);
    chk("post_rst_err_count", err_cnt, err0);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);

    chk("rdy_with_busy", rdy_busy_bad, 0);
    chk("rdy_and_err_overlap", both_bad, 0);
    chk("pulse_width", long_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
